// File: rtl/eth_pkg.sv
// Shared types and constants for the bit-serial Ethernet receive frame path.
package eth_pkg;

   // Frame controller states.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRE    = 3'd1,
      DATA   = 3'd2,
      STATUS = 3'd3,
      DROP   = 3'd4
   } eth_state_t;

   // Start-of-frame delimiter as it sits in a right-shifting pattern register
   // (bit 0 = oldest bit): arrival order 1,0,1,0,1,0,1,1.
   localparam logic [7:0] ETH_SFD = 8'hD5;

   // Width of the byte count carried in the status word.
   localparam int ETH_CNT_W = 11;

   // One status word per received frame.
   typedef struct packed {
      logic                 good;
      logic                 err_crc;
      logic                 err_align;
      logic                 err_runt;
      logic                 err_long;
      logic [ETH_CNT_W-1:0] bytes;
   } eth_frm_status_t;

   // 8-bit increment that sticks at its maximum value.
   function automatic logic [7:0] sat_inc8(input logic [7:0] val);
      if (val == 8'hFF) begin
         return val;
      end
      return val + 8'd1;
   endfunction

endpackage

// File: rtl/eth_rx_byte_asm.sv
// Serial-to-byte assembler: LSB-first shift register, bit index and a
// one-cycle byte_vld pulse in the cycle after the eighth bit.
module eth_rx_byte_asm
   import eth_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clr,
   input  logic       shift_en,
   input  logic       bit_data,
   output logic [2:0] bit_idx,
   output logic       byte_vld,
   output logic [7:0] byte_data
);

   logic [7:0] sh_reg;
   logic [7:0] sh_next;
   logic [2:0] idx_reg;
   logic       vld_reg;
   logic [7:0] data_reg;
   logic       byte_done;

   genvar gi;

   // New bit enters at the top so that after eight shifts the first bit
   // received lands in bit 0.
   assign sh_next[7] = bit_data;
   generate
      for (gi = 0; gi < 7; gi++) begin : g_shift
         assign sh_next[gi] = sh_reg[gi+1];
      end
   endgenerate

   assign byte_done = shift_en && (idx_reg == 3'd7);

   // Shift register, wrapping bit index and the completed-byte register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_reg   <= '0;
         idx_reg  <= '0;
         vld_reg  <= 1'b0;
         data_reg <= '0;
      end else begin
         vld_reg <= byte_done;
         if (clr) begin
            sh_reg  <= '0;
            idx_reg <= '0;
         end else if (shift_en) begin
            sh_reg  <= sh_next;
            idx_reg <= idx_reg + 3'd1;
            if (byte_done) begin
               data_reg <= sh_next;
            end
         end
      end
   end

   assign bit_idx   = idx_reg;
   assign byte_vld  = vld_reg;
   assign byte_data = data_reg;

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// Bit-serial Ethernet receive frame controller: preamble/SFD detection,
// FCS checker sequencing, byte assembly and one status word per frame.
module eth_rx_frame_ctrl
   import eth_pkg::*;
#(
   parameter int PRE_MIN_BITS = 16,
   parameter int MIN_BYTES    = 64,
   parameter int MAX_BYTES    = 1518,
   parameter int CNT_W        = ETH_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             rx_dv,
   input  logic             bit_vld,
   input  logic             bit_data,
   output logic             fcs_rst,
   output logic             fcs_en,
   output logic             fcs_bit,
   input  logic             fcs_ok,
   output logic             byte_vld,
   output logic [7:0]       byte_data,
   output logic             frm_done,
   output logic             frm_good,
   output logic             err_crc,
   output logic             err_align,
   output logic             err_runt,
   output logic             err_long,
   output logic [CNT_W-1:0] frm_bytes
);

   localparam logic [7:0]       PRE_MIN_L = 8'(PRE_MIN_BITS);
   localparam logic [CNT_W-1:0] MIN_L     = CNT_W'(MIN_BYTES);
   localparam logic [CNT_W-1:0] MAX_L     = CNT_W'(MAX_BYTES);
   localparam logic [CNT_W-1:0] CNT_SAT   = '1;

   eth_state_t      state_reg, state_next;
   logic [7:0]      pat_reg, pat_next;
   logic [7:0]      pre_cnt_reg, pre_cnt_next;
   logic [CNT_W-1:0] byte_cnt_reg, byte_cnt_next;
   eth_frm_status_t status_reg, status_next;
   logic            frm_done_reg, frm_done_next;
   logic            fcs_rst_reg;

   logic            accept;
   logic [7:0]      pat_shift;
   logic [7:0]      pre_cnt_inc;
   logic            asm_clr;
   logic [2:0]      bit_idx;
   logic            flag_crc, flag_align, flag_runt, flag_long;

   // A bit only counts while carrier is present.
   assign accept      = rx_dv && bit_vld;
   assign pat_shift   = {bit_data, pat_reg[7:1]};
   assign pre_cnt_inc = sat_inc8(pre_cnt_reg);

   // The checker advances on every accepted data bit; the bit itself passes through.
   assign fcs_en  = (state_reg == DATA) && accept;
   assign fcs_bit = bit_data;

   // Error flags as seen during the STATUS cycle.
   assign flag_crc   = !fcs_ok;
   assign flag_align = (bit_idx != 3'd0);
   assign flag_runt  = (byte_cnt_reg < MIN_L);
   assign flag_long  = (byte_cnt_reg > MAX_L);

   eth_rx_byte_asm u_byte_asm (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr       (asm_clr),
      .shift_en  (fcs_en),
      .bit_data  (bit_data),
      .bit_idx   (bit_idx),
      .byte_vld  (byte_vld),
      .byte_data (byte_data)
   );

   // Next-state, preamble tracking, byte counting and status generation.
   always_comb begin
      state_next    = state_reg;
      pat_next      = pat_reg;
      pre_cnt_next  = pre_cnt_reg;
      byte_cnt_next = byte_cnt_reg;
      status_next   = status_reg;
      frm_done_next = 1'b0;
      asm_clr       = 1'b0;
      case (state_reg)
         IDLE: begin
            asm_clr       = 1'b1;
            byte_cnt_next = '0;
            if (accept) begin
               pat_next     = {bit_data, 7'b0};
               pre_cnt_next = 8'd1;
               state_next   = PRE;
            end
         end
         PRE: begin
            asm_clr = 1'b1;
            if (!rx_dv) begin
               state_next = IDLE;
            end else if (bit_vld) begin
               pat_next     = pat_shift;
               pre_cnt_next = pre_cnt_inc;
               if ((pat_shift == ETH_SFD) && (pre_cnt_inc >= PRE_MIN_L)) begin
                  state_next = DATA;
               end else if (bit_data == pat_reg[7]) begin
                  // Repeated bit that does not close a valid SFD: not a preamble.
                  state_next = DROP;
               end
            end
         end
         DATA: begin
            if (!rx_dv) begin
               state_next = STATUS;
            end else if (bit_vld && (bit_idx == 3'd7) && (byte_cnt_reg != CNT_SAT)) begin
               byte_cnt_next = byte_cnt_reg + CNT_W'(1);
            end
         end
         STATUS: begin
            status_next.err_crc   = flag_crc;
            status_next.err_align = flag_align;
            status_next.err_runt  = flag_runt;
            status_next.err_long  = flag_long;
            status_next.good      = !(flag_crc || flag_align || flag_runt || flag_long);
            status_next.bytes     = ETH_CNT_W'(byte_cnt_reg);
            frm_done_next         = 1'b1;
            state_next            = IDLE;
         end
         DROP: begin
            asm_clr = 1'b1;
            if (!rx_dv) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers; the checker is held in reset outside DATA.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         pat_reg      <= '0;
         pre_cnt_reg  <= '0;
         byte_cnt_reg <= '0;
         status_reg   <= '0;
         frm_done_reg <= 1'b0;
         fcs_rst_reg  <= 1'b1;
      end else begin
         state_reg    <= state_next;
         pat_reg      <= pat_next;
         pre_cnt_reg  <= pre_cnt_next;
         byte_cnt_reg <= byte_cnt_next;
         status_reg   <= status_next;
         frm_done_reg <= frm_done_next;
         fcs_rst_reg  <= (state_next != DATA);
      end
   end

   assign fcs_rst   = fcs_rst_reg;
   assign frm_done  = frm_done_reg;
   assign frm_good  = status_reg.good;
   assign err_crc   = status_reg.err_crc;
   assign err_align = status_reg.err_align;
   assign err_runt  = status_reg.err_runt;
   assign err_long  = status_reg.err_long;
   assign frm_bytes = CNT_W'(status_reg.bytes);

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Directed bench for eth_rx_frame_ctrl with a serial CRC-32 checker attached.
module tb_eth_rx_frame_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx_dv = 1'b0;
   logic        bit_vld = 1'b0;
   logic        bit_data = 1'b0;
   logic        fcs_rst, fcs_en, fcs_bit, fcs_ok;
   logic        byte_vld, frm_done, frm_good;
   logic        err_crc, err_align, err_runt, err_long;
   logic [7:0]  byte_data;
   logic [10:0] frm_bytes;

   always #5 clk = ~clk;

   eth_rx_frame_ctrl dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rx_dv     (rx_dv),
      .bit_vld   (bit_vld),
      .bit_data  (bit_data),
      .fcs_rst   (fcs_rst),
      .fcs_en    (fcs_en),
      .fcs_bit   (fcs_bit),
      .fcs_ok    (fcs_ok),
      .byte_vld  (byte_vld),
      .byte_data (byte_data),
      .frm_done  (frm_done),
      .frm_good  (frm_good),
      .err_crc   (err_crc),
      .err_align (err_align),
      .err_runt  (err_runt),
      .err_long  (err_long),
      .frm_bytes (frm_bytes)
   );

   // Reflected CRC-32 step, one bit.
   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
      logic fb;
      fb = c[0] ^ b;
      return {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
   endfunction

   // Serial FCS checker: residue 0xDEBB20E3 after data plus a correct FCS.
   logic [31:0] chk_crc = 32'hFFFFFFFF;
   always @(posedge clk) begin
      if (fcs_rst) chk_crc <= 32'hFFFFFFFF;
      else if (fcs_en) chk_crc <= crc_step(chk_crc, fcs_bit);
   end
   assign fcs_ok = (chk_crc == 32'hDEBB20E3);

   typedef struct packed {
      int pre; int npay; bit fcs; bit flip; int extra; bit zero;
      int exp_vld; bit exp_done; bit exp_good; bit exp_crc; bit exp_align;
      bit exp_runt; bit exp_long; int exp_bytes;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   int n_chk = 0;
   int n_fail = 0;
   int vld_cnt, done_cnt, bd_err, rx_idx, last_bytes;
   int cap_good, cap_crc, cap_align, cap_runt, cap_long, cap_bytes;
   bit         bitq[$];
   logic [7:0] fb[$];
   logic [7:0] expb[$];

   task automatic check(input string nm, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
      end
   endtask

   // One clock: sample outputs on the falling edge, return just after the rising edge.
   task automatic tick();
      @(negedge clk);
      if (byte_vld) begin
         vld_cnt++;
         if (rx_idx >= expb.size() || byte_data != expb[rx_idx]) bd_err++;
         rx_idx++;
      end
      if (frm_done) begin
         done_cnt++;
         cap_good = int'(frm_good); cap_crc = int'(err_crc); cap_align = int'(err_align);
         cap_runt = int'(err_runt); cap_long = int'(err_long); cap_bytes = int'(frm_bytes);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bits(input int n);
      for (int k = 0; k < n; k++) begin
         rx_dv = 1'b1; bit_vld = 1'b1; bit_data = bitq[k];
         tick();
      end
   endtask

   task automatic idle(input int n);
      rx_dv = 1'b0; bit_vld = 1'b0; bit_data = 1'b0;
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic clr_counts();
      vld_cnt = 0; done_cnt = 0; bd_err = 0; rx_idx = 0;
      expb.delete();
   endtask

   task automatic set_exp(input int n);
      for (int k = 0; k < n; k++) expb.push_back(fb[k]);
   endtask

   // Preamble ending in the SFD, payload, optional FCS, optional trailing zero bits.
   task automatic build(input int pre, input int npay, input bit with_fcs, input bit flip,
                        input int extra, input bit zero, input int seed);
      logic [31:0] crc;
      logic [31:0] fcs;
      logic [7:0]  b;
      bitq.delete(); fb.delete();
      for (int k = 0; k < pre; k++)
         bitq.push_back((k == pre - 1) || (((pre - 2 - k) % 2) == 0));
      crc = 32'hFFFFFFFF;
      for (int i = 0; i < npay; i++) begin
         b = zero ? 8'h00 : 8'(i * 37 + seed);
         fb.push_back(b);
         for (int j = 0; j < 8; j++) crc = crc_step(crc, b[j]);
      end
      if (with_fcs) begin
         fcs = ~crc;
         for (int j = 0; j < 4; j++) fb.push_back(fcs[8*j +: 8]);
      end
      if (flip) begin
         b = fb[10]; b[3] = ~b[3]; fb[10] = b;
      end
      for (int i = 0; i < fb.size(); i++) begin
         b = fb[i];
         for (int j = 0; j < 8; j++) bitq.push_back(b[j]);
      end
      for (int k = 0; k < extra; k++) bitq.push_back(1'b0);
   endtask

   task automatic run_vec(input int id, input vec_t v);
      clr_counts();
      build(v.pre, v.npay, v.fcs, v.flip, v.extra, v.zero, id);
      set_exp(v.exp_vld);
      drive_bits(bitq.size());
      idle(6);
      $display("vec %0d: pre=%0d bytes_in=%0d vld=%0d done=%0d good=%0d crc=%0d align=%0d runt=%0d long=%0d frm_bytes=%0d",
               id, v.pre, fb.size(), vld_cnt, done_cnt, cap_good, cap_crc, cap_align, cap_runt, cap_long, cap_bytes);
      check($sformatf("vec%0d byte_vld count", id), vld_cnt, v.exp_vld);
      check($sformatf("vec%0d frm_done count", id), done_cnt, int'(v.exp_done));
      check($sformatf("vec%0d byte_data errors", id), bd_err, 0);
      if (v.exp_done) begin
         check($sformatf("vec%0d frm_good", id), cap_good, int'(v.exp_good));
         check($sformatf("vec%0d err_crc", id), cap_crc, int'(v.exp_crc));
         check($sformatf("vec%0d err_align", id), cap_align, int'(v.exp_align));
         check($sformatf("vec%0d err_runt", id), cap_runt, int'(v.exp_runt));
         check($sformatf("vec%0d err_long", id), cap_long, int'(v.exp_long));
         check($sformatf("vec%0d frm_bytes", id), cap_bytes, v.exp_bytes);
         last_bytes = v.exp_bytes;
      end else begin
         check($sformatf("vec%0d frm_bytes held", id), int'(frm_bytes), last_bytes);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      //            pre  npay  fcs   flip  extra zero  vld  done  good  crc   align runt  long  bytes
      vecs[0]  = '{16,   60, 1'b1, 1'b0, 0, 1'b1,   64, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,   64};
      vecs[1]  = '{16,   60, 1'b1, 1'b1, 0, 1'b1,   64, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,   64};
      vecs[2]  = '{16,   60, 1'b1, 1'b0, 5, 1'b1,   64, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,   64};
      vecs[3]  = '{16,   36, 1'b1, 1'b0, 0, 1'b0,   40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,   40};
      vecs[4]  = '{16, 1516, 1'b1, 1'b0, 0, 1'b0, 1520, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1520};
      vecs[5]  = '{ 8,   60, 1'b1, 1'b0, 0, 1'b0,    0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,    0};
      vecs[6]  = '{15,   60, 1'b1, 1'b0, 0, 1'b0,    0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,    0};
      vecs[7]  = '{16,    0, 1'b0, 1'b0, 0, 1'b0,    0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,    0};
      vecs[8]  = '{300,  60, 1'b1, 1'b0, 0, 1'b0,   64, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,   64};
      vecs[9]  = '{16,   59, 1'b1, 1'b0, 0, 1'b0,   63, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,   63};
      vecs[10] = '{16, 1514, 1'b1, 1'b0, 0, 1'b0, 1518, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1518};
      vecs[11] = '{16, 1515, 1'b1, 1'b0, 0, 1'b0, 1519, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1519};

      clr_counts();
      cap_good = 0; cap_crc = 0; cap_align = 0; cap_runt = 0; cap_long = 0; cap_bytes = 0;
      last_bytes = 0;

      // Reset values.
      idle(3);
      check("reset fcs_rst", int'(fcs_rst), 1);
      check("reset fcs_en", int'(fcs_en), 0);
      check("reset byte_vld", int'(byte_vld), 0);
      check("reset byte_data", int'(byte_data), 0);
      check("reset frm_done", int'(frm_done), 0);
      check("reset frm_good", int'(frm_good), 0);
      check("reset frm_bytes", int'(frm_bytes), 0);
      reset_n = 1'b1;
      idle(2);

      for (int v = 0; v < NV; v++) run_vec(v, vecs[v]);

      // rx_dv back one cycle after the frame: its first bit falls in STATUS and is
      // ignored, leaving only 15 preamble bits, so the second frame is dropped.
      clr_counts();
      build(16, 60, 1'b1, 1'b0, 0, 1'b1, 0);
      set_exp(64);
      drive_bits(bitq.size());
      idle(1);
      drive_bits(bitq.size());
      idle(6);
      $display("seq status_rx_dv: vld=%0d done=%0d good=%0d frm_bytes=%0d", vld_cnt, done_cnt, cap_good, cap_bytes);
      check("stat_rxdv byte_vld count", vld_cnt, 64);
      check("stat_rxdv frm_done count", done_cnt, 1);
      check("stat_rxdv byte_data errors", bd_err, 0);
      check("stat_rxdv frm_good", cap_good, 1);
      check("stat_rxdv frm_bytes", cap_bytes, 64);

      // Asynchronous reset three bits into byte 31 of a frame.
      clr_counts();
      build(16, 60, 1'b1, 1'b0, 0, 1'b0, 3);
      set_exp(30);
      drive_bits(16 + 30 * 8 + 3);
      rx_dv = 1'b0; bit_vld = 1'b0; bit_data = 1'b0;
      @(negedge clk);
      check("midrst fcs_rst before", int'(fcs_rst), 0);
      check("midrst byte_data before", int'(byte_data), int'(fb[29]));
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst fcs_rst", int'(fcs_rst), 1);
      check("midrst byte_data", int'(byte_data), 0);
      check("midrst byte_vld", int'(byte_vld), 0);
      check("midrst frm_good", int'(frm_good), 0);
      check("midrst frm_bytes", int'(frm_bytes), 0);
      @(posedge clk);
      #1;
      idle(3);
      reset_n = 1'b1;
      idle(4);
      $display("seq mid_reset: vld=%0d done=%0d", vld_cnt, done_cnt);
      check("midrst byte_vld count", vld_cnt, 30);
      check("midrst frm_done count", done_cnt, 0);
      check("midrst byte_data errors", bd_err, 0);
      last_bytes = 0;

      // Clean frame after the reset.
      run_vec(100, vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
